// File: rtl/frame_sync_pkg.sv
// frame_sync_pkg: shared types and constants for the frame_sync video re-framer.
//   fs_state_e      - re-framing FSM states
//   ERR_*           - bit positions inside err_sticky
//   ctr_width()     - counter width helper that never returns zero
package frame_sync_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ACTIVE    = 3'd1,
    ST_PAD_LINE  = 3'd2,
    ST_SKIP_LINE = 3'd3,
    ST_PAD_FRAME = 3'd4
  } fs_state_e;

  localparam int unsigned ERR_EARLY_TLAST   = 0;
  localparam int unsigned ERR_MISSING_TLAST = 1;
  localparam int unsigned ERR_MID_TUSER     = 2;
  localparam int unsigned ERR_W             = 3;

  // Width of a counter that must hold 0..n-1; a 1-entry range still gets 1 bit.
  function automatic int unsigned ctr_width(input int unsigned n);
    if (n > 32'd1) begin
      return int'($clog2(n));
    end else begin
      return 32'd1;
    end
  endfunction

endpackage

// File: rtl/frame_sync.sv
// frame_sync: re-frames a raw AXI4-Stream video feed into strictly
// FRAME_WIDTH x FRAME_HEIGHT frames. Output tuser/tlast are regenerated from
// internal h/v counters. Short lines are padded, long lines are truncated,
// and an unexpected start-of-frame pads the current frame to its end before
// the new frame begins. Pad pixels repeat the last forwarded input pixel.
//
// Ports
//   clk, rst_n            - clock, asynchronous active-low reset
//   s_axis_*              - raw video slave (tdata/tvalid/tlast/tuser, tready)
//   m_axis_*              - clean video master (single output register)
//   err_sticky[2:0]       - bit0 early tlast, bit1 missing tlast, bit2 mid-frame tuser
//   err_clr               - clears err_sticky (a same-cycle new event still sets)
//   frame_done            - one-cycle pulse while the last pixel of a frame is presented
//   err_cnt[15:0]         - only with FRAME_SYNC_STATS_EN defined: saturating error-event count
module frame_sync
  import frame_sync_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned FRAME_WIDTH  = 640,
  parameter int unsigned FRAME_HEIGHT = 512
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  input  logic                  m_axis_tready,
  output logic [2:0]            err_sticky,
  input  logic                  err_clr,
  output logic                  frame_done
`ifdef FRAME_SYNC_STATS_EN
  ,
  output logic [15:0]           err_cnt
`endif
);

  localparam int unsigned HW = ctr_width(FRAME_WIDTH);
  localparam int unsigned VW = ctr_width(FRAME_HEIGHT);
  localparam logic [HW-1:0] H_LAST = HW'(FRAME_WIDTH - 1);
  localparam logic [VW-1:0] V_LAST = VW'(FRAME_HEIGHT - 1);

  fs_state_e             state_q, state_d;
  logic [HW-1:0]         h_q, h_d;
  logic [VW-1:0]         v_q, v_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                  m_valid_q, m_valid_d;
  logic                  m_last_q, m_last_d;
  logic                  m_user_q, m_user_d;
  logic [DATA_WIDTH-1:0] pend_data_q, pend_data_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [DATA_WIDTH-1:0] pad_q, pad_d;
  logic [ERR_W-1:0]      err_q, err_d;
  logic                  frame_done_q, frame_done_d;

  logic                  out_ready_s;
  logic                  s_ready_s;
  logic                  at_origin_s;
  logic                  last_px_s;
  logic                  eof_s;
  logic                  fwd_s;
  logic                  emit_s;
  logic [DATA_WIDTH-1:0] emit_data_s;
  logic [ERR_W-1:0]      err_set_s;
  logic [ERR_W-1:0]      err_base_s;

  // h/v always point at the position the next emitted beat will occupy.
  assign out_ready_s = !m_valid_q || m_axis_tready;
  assign at_origin_s = (h_q == {HW{1'b0}}) && (v_q == {VW{1'b0}});
  assign last_px_s   = (h_q == H_LAST);
  assign eof_s       = last_px_s && (v_q == V_LAST);

  // Slave ready: follow the output register except while generating pads.
  always_comb begin
    case (state_q)
      ST_IDLE, ST_ACTIVE, ST_SKIP_LINE: s_ready_s = out_ready_s;
      default:                          s_ready_s = 1'b0;
    endcase
  end

  // FSM next state, output-register load, h/v advance and error events.
  always_comb begin
    state_d      = state_q;
    h_d          = h_q;
    v_d          = v_q;
    m_data_d     = m_data_q;
    m_last_d     = m_last_q;
    m_user_d     = m_user_q;
    m_valid_d    = out_ready_s ? 1'b0 : m_valid_q;
    pend_data_d  = pend_data_q;
    pend_valid_d = pend_valid_q;
    pad_d        = pad_q;
    frame_done_d = 1'b0;
    err_set_s    = {ERR_W{1'b0}};
    fwd_s        = 1'b0;
    emit_s       = 1'b0;
    emit_data_s  = pad_q;

    if (out_ready_s) begin
      case (state_q)
        ST_IDLE: begin
          // Everything before a start-of-frame is dropped.
          if (s_axis_tvalid && s_axis_tuser) begin
            fwd_s = 1'b1;
          end else begin
            fwd_s = 1'b0;
          end
        end
        ST_ACTIVE: begin
          if (s_axis_tvalid) begin
            if (s_axis_tuser && !at_origin_s) begin
              // Hold the new frame's first pixel until this frame is padded out.
              pend_data_d                = s_axis_tdata;
              pend_valid_d               = 1'b1;
              err_set_s[ERR_MID_TUSER]   = 1'b1;
              state_d                    = ST_PAD_FRAME;
            end else begin
              fwd_s = 1'b1;
            end
          end else begin
            fwd_s = 1'b0;
          end
        end
        ST_SKIP_LINE: begin
          if (s_axis_tvalid) begin
            if (s_axis_tuser) begin
              if (at_origin_s) begin
                // Frame already closed: this is a legitimate new frame.
                fwd_s = 1'b1;
              end else begin
                pend_data_d              = s_axis_tdata;
                pend_valid_d             = 1'b1;
                err_set_s[ERR_MID_TUSER] = 1'b1;
                state_d                  = ST_PAD_FRAME;
              end
            end else if (s_axis_tlast) begin
              // Counters sit at the origin when the truncated line ended the frame.
              state_d = at_origin_s ? ST_IDLE : ST_ACTIVE;
            end else begin
              state_d = ST_SKIP_LINE;
            end
          end else begin
            state_d = ST_SKIP_LINE;
          end
        end
        ST_PAD_LINE: begin
          emit_s      = 1'b1;
          emit_data_s = pad_q;
          if (last_px_s) begin
            state_d = eof_s ? ST_IDLE : ST_ACTIVE;
          end else begin
            state_d = ST_PAD_LINE;
          end
        end
        ST_PAD_FRAME: begin
          if (at_origin_s) begin
            if (pend_valid_q) begin
              // The held start-of-frame pixel becomes the new (0,0).
              emit_s       = 1'b1;
              emit_data_s  = pend_data_q;
              pad_d        = pend_data_q;
              pend_valid_d = 1'b0;
              state_d      = eof_s ? ST_IDLE : ST_ACTIVE;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            emit_s      = 1'b1;
            emit_data_s = pad_q;
            state_d     = ST_PAD_FRAME;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase

      // A forwarded input beat is checked against the regenerated line end.
      if (fwd_s) begin
        emit_s      = 1'b1;
        emit_data_s = s_axis_tdata;
        pad_d       = s_axis_tdata;
        if (s_axis_tlast && !last_px_s) begin
          err_set_s[ERR_EARLY_TLAST] = 1'b1;
          state_d                    = ST_PAD_LINE;
        end else if (last_px_s && !s_axis_tlast) begin
          err_set_s[ERR_MISSING_TLAST] = 1'b1;
          state_d                      = ST_SKIP_LINE;
        end else if (eof_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ACTIVE;
        end
      end else begin
        fwd_s = 1'b0;
      end

      if (emit_s) begin
        m_valid_d = 1'b1;
        m_data_d  = emit_data_s;
        m_user_d  = at_origin_s;
        m_last_d  = last_px_s;
        if (eof_s) begin
          h_d          = {HW{1'b0}};
          v_d          = {VW{1'b0}};
          frame_done_d = 1'b1;
        end else if (last_px_s) begin
          h_d = {HW{1'b0}};
          v_d = v_q + 1'b1;
        end else begin
          h_d = h_q + 1'b1;
        end
      end else begin
        m_data_d = m_data_q;
      end
    end else begin
      // Stalled downstream: everything holds.
      state_d = state_q;
    end
  end

  // Sticky errors: clear first, then OR in this cycle's events so a set wins.
  always_comb begin
    if (err_clr) begin
      err_base_s = {ERR_W{1'b0}};
    end else begin
      err_base_s = err_q;
    end
    err_d = err_base_s | err_set_s;
  end

  // State, counters, output register, pending/pad storage and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      h_q          <= {HW{1'b0}};
      v_q          <= {VW{1'b0}};
      m_data_q     <= {DATA_WIDTH{1'b0}};
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      m_user_q     <= 1'b0;
      pend_data_q  <= {DATA_WIDTH{1'b0}};
      pend_valid_q <= 1'b0;
      pad_q        <= {DATA_WIDTH{1'b0}};
      err_q        <= {ERR_W{1'b0}};
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      h_q          <= h_d;
      v_q          <= v_d;
      m_data_q     <= m_data_d;
      m_valid_q    <= m_valid_d;
      m_last_q     <= m_last_d;
      m_user_q     <= m_user_d;
      pend_data_q  <= pend_data_d;
      pend_valid_q <= pend_valid_d;
      pad_q        <= pad_d;
      err_q        <= err_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef FRAME_SYNC_STATS_EN
  logic [15:0] err_cnt_q, err_cnt_d, cnt_base_s;

  // Saturating count of error cycles; simultaneous events count once.
  always_comb begin
    if (err_clr) begin
      cnt_base_s = 16'd0;
    end else begin
      cnt_base_s = err_cnt_q;
    end
    if ((err_set_s != {ERR_W{1'b0}}) && (cnt_base_s != 16'hFFFF)) begin
      err_cnt_d = cnt_base_s + 16'd1;
    end else begin
      err_cnt_d = cnt_base_s;
    end
  end

  // Error counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= 16'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

  assign s_axis_tready = s_ready_s;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tlast  = m_last_q;
  assign m_axis_tuser  = m_user_q;
  assign err_sticky    = err_q;
  assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_frame_sync.sv
// tb_frame_sync: directed self-checking bench for frame_sync at 4x2 pixels.
module tb_frame_sync;

  localparam int DW = 8;
  localparam int FW = 4;
  localparam int FH = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] s_data;
  logic          s_valid, s_last, s_user;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tlast, m_axis_tuser;
  logic          m_rdy;
  logic [2:0]    err_sticky;
  logic          err_clr;
  logic          frame_done;
`ifdef FRAME_SYNC_STATS_EN
  logic [15:0]   err_cnt;
`endif

  always #5 clk = ~clk;

  frame_sync #(.DATA_WIDTH(DW), .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_data),
    .s_axis_tvalid (s_valid),
    .s_axis_tlast  (s_last),
    .s_axis_tuser  (s_user),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tready (m_rdy),
    .err_sticky    (err_sticky),
    .err_clr       (err_clr),
    .frame_done    (frame_done)
`ifdef FRAME_SYNC_STATS_EN
    ,
    .err_cnt       (err_cnt)
`endif
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Output monitor: records handshakes {data,last,user}, counts frame_done,
  // and checks the master holds steady while stalled.
  logic [9:0]  obs_q[$];
  int          fd_cnt = 0;
  logic        prev_stall = 1'b0;
  logic [10:0] prev_vec = 11'd0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall)
        check_eq("stall_hold", 32'({m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser}),
                 32'(prev_vec));
      if (m_axis_tvalid && m_rdy) obs_q.push_back({m_axis_tdata, m_axis_tlast, m_axis_tuser});
      if (frame_done) fd_cnt <= fd_cnt + 1;
      prev_stall <= m_axis_tvalid && !m_rdy;
      prev_vec   <= {m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser};
    end else begin
      prev_stall <= 1'b0;
    end
  end

  logic [9:0] exp_q[$];
  int         obs_base = 0;
  int         fd_base  = 0;
  bit         tog_en   = 1'b0;

  task automatic exp_beat(input logic [7:0] d, input logic l, input logic u);
    exp_q.push_back({d, l, u});
  endtask

  // Called at posedge+1; returns at posedge+1 right after the handshake edge.
  task automatic send(input logic [7:0] d, input logic l, input logic u);
    int n;
    s_data = d; s_last = l; s_user = u; s_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!s_axis_tready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!s_axis_tready) begin
      check_eq("send_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
    end else begin
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
  endtask

  task automatic compare_out(input string tag);
    check_eq({tag, "_count"}, 32'(obs_q.size() - obs_base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (obs_base + i < obs_q.size())
        check_eq($sformatf("%s_beat%0d", tag, i), 32'(obs_q[obs_base + i]), 32'(exp_q[i]));
    end
    exp_q.delete();
    obs_base = obs_q.size();
  endtask

  task automatic send_clean_frame(input logic [7:0] base);
    for (int i = 0; i < FW * FH; i++) begin
      send(base + 8'(i), (i % FW) == FW - 1, i == 0);
      exp_beat(base + 8'(i), (i % FW) == FW - 1, i == 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; s_data = 8'd0; s_valid = 1'b0; s_last = 1'b0; s_user = 1'b0;
    m_rdy = 1'b1; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    check_eq("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check_eq("rst_tdata",  32'(m_axis_tdata),  32'd0);
    check_eq("rst_tlast",  32'(m_axis_tlast),  32'd0);
    check_eq("rst_tuser",  32'(m_axis_tuser),  32'd0);
    check_eq("rst_err",    32'(err_sticky),    32'd0);
    check_eq("rst_fdone",  32'(frame_done),    32'd0);
    rst_n = 1'b1;
    idle_cycles(2);
    check_eq("idle_ready", 32'(s_axis_tready), 32'd1);

    // Clean frame, preceded by a stray beat that IDLE must drop
    fd_base = fd_cnt;
    send(8'h55, 1'b0, 1'b0);
    check_eq("idle_drop", 32'(m_axis_tvalid), 32'd0);
    send(8'd1, 1'b0, 1'b1);
    exp_beat(8'd1, 1'b0, 1'b1);
    check_eq("lat_tvalid", 32'(m_axis_tvalid), 32'd1);
    check_eq("lat_tdata",  32'(m_axis_tdata),  32'd1);
    check_eq("lat_tuser",  32'(m_axis_tuser),  32'd1);
    for (int i = 2; i <= 8; i++) begin
      send(8'(i), (i == 4) || (i == 8), 1'b0);
      exp_beat(8'(i), (i == 4) || (i == 8), 1'b0);
    end
    idle_cycles(6);
    compare_out("clean");
    check_eq("clean_fdone", 32'(fd_cnt - fd_base), 32'd1);
    check_eq("clean_err",   32'(err_sticky),       32'd0);

    // Early tlast on line 0: padded with the last pixel
    pulse_clr();
    send(8'd1, 1'b0, 1'b1);
    send(8'd2, 1'b1, 1'b0);
    check_eq("padline_ready", 32'(s_axis_tready), 32'd0);
    for (int i = 5; i <= 8; i++) send(8'(i), i == 8, 1'b0);
    exp_beat(8'd1, 1'b0, 1'b1); exp_beat(8'd2, 1'b0, 1'b0);
    exp_beat(8'd2, 1'b0, 1'b0); exp_beat(8'd2, 1'b1, 1'b0);
    exp_beat(8'd5, 1'b0, 1'b0); exp_beat(8'd6, 1'b0, 1'b0);
    exp_beat(8'd7, 1'b0, 1'b0); exp_beat(8'd8, 1'b1, 1'b0);
    idle_cycles(6);
    compare_out("early");
    check_eq("early_err", 32'(err_sticky), 32'd1);

    // Missing tlast on line 0: extra beats dropped
    pulse_clr();
    for (int i = 1; i <= 6; i++) send(8'(i), i == 6, i == 1);
    for (int i = 7; i <= 10; i++) send(8'(i), i == 10, 1'b0);
    exp_beat(8'd1, 1'b0, 1'b1); exp_beat(8'd2, 1'b0, 1'b0);
    exp_beat(8'd3, 1'b0, 1'b0); exp_beat(8'd4, 1'b1, 1'b0);
    exp_beat(8'd7, 1'b0, 1'b0); exp_beat(8'd8, 1'b0, 1'b0);
    exp_beat(8'd9, 1'b0, 1'b0); exp_beat(8'd10, 1'b1, 1'b0);
    idle_cycles(6);
    compare_out("long");
    check_eq("long_err", 32'(err_sticky), 32'd2);

    // Mid-frame tuser; err_clr coincides with the event so bit1 clears, bit2 sets
    fd_base = fd_cnt;
    send(8'd1, 1'b0, 1'b1);
    send(8'd2, 1'b0, 1'b0);
    send(8'd3, 1'b0, 1'b0);
    err_clr = 1'b1;
    send(8'd9, 1'b0, 1'b1);
    err_clr = 1'b0;
    for (int i = 10; i <= 16; i++) send(8'(i), (i == 12) || (i == 16), 1'b0);
    exp_beat(8'd1, 1'b0, 1'b1); exp_beat(8'd2, 1'b0, 1'b0);
    exp_beat(8'd3, 1'b0, 1'b0); exp_beat(8'd3, 1'b1, 1'b0);
    exp_beat(8'd3, 1'b0, 1'b0); exp_beat(8'd3, 1'b0, 1'b0);
    exp_beat(8'd3, 1'b0, 1'b0); exp_beat(8'd3, 1'b1, 1'b0);
    for (int i = 9; i <= 16; i++) exp_beat(8'(i), (i == 12) || (i == 16), i == 9);
    idle_cycles(6);
    compare_out("midsof");
    check_eq("midsof_err",   32'(err_sticky),       32'd4);
    check_eq("midsof_fdone", 32'(fd_cnt - fd_base), 32'd2);
`ifdef FRAME_SYNC_STATS_EN
    check_eq("midsof_cnt", 32'(err_cnt), 32'd1);
`endif

    // Backpressure 1010...: nothing lost, duplicated or changed while stalled
    pulse_clr();
    fd_base = fd_cnt;
    tog_en = 1'b1;
    fork
      begin
        while (tog_en) begin
          @(posedge clk); #1;
          m_rdy = ~m_rdy;
        end
      end
    join_none
    send_clean_frame(8'h21);
    idle_cycles(20);
    tog_en = 1'b0;
    @(posedge clk); #2;
    m_rdy = 1'b1;
    idle_cycles(2);
    compare_out("stall");
    check_eq("stall_fdone", 32'(fd_cnt - fd_base), 32'd1);
    check_eq("stall_err",   32'(err_sticky),       32'd0);

    // Reset mid-line, then the block must wait for a fresh start-of-frame
    send(8'h31, 1'b0, 1'b1);
    send(8'h32, 1'b0, 1'b0);
    rst_n = 1'b0;
    idle_cycles(2);
    check_eq("midrst_tvalid", 32'(m_axis_tvalid), 32'd0);
    rst_n = 1'b1;
    idle_cycles(1);
    obs_base = obs_q.size();
    fd_base  = fd_cnt;
    send(8'h40, 1'b0, 1'b0);
    send(8'h41, 1'b1, 1'b0);
    idle_cycles(4);
    check_eq("postrst_idle", 32'(m_axis_tvalid), 32'd0);
    compare_out("postrst_drop");
    send_clean_frame(8'h51);
    idle_cycles(6);
    compare_out("postrst");
    check_eq("postrst_fdone", 32'(fd_cnt - fd_base), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
